// File: rtl/reg_bus_if.sv
// Register-bus bundle shared by two requesters and one peripheral port.
// slave = arbiter view, master = requester/peripheral view.
interface reg_bus_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  logic [ADDR_W-1:0] per_address;
  logic              per_data_write;
  logic [DATA_W-1:0] per_data_in;
  logic [DATA_W-1:0] per_data_out;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  per_data_out,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output per_address, per_data_write, per_data_in
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output per_data_out,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  per_address, per_data_write, per_data_in
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Two-requester register-port arbiter: IDLE -> ISSUE -> RESP, one access in flight.
// Define REG_ARB_FIXED_PRIO_EN for fixed priority to requester 0 instead of round-robin.
module reg_bus_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  reg_bus_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              accept_s;
  logic              grant_s;
  logic              sel_write_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  logic              owner_r;
  logic              write_r;
  logic [ADDR_W-1:0] per_address_r;
  logic [DATA_W-1:0] per_data_in_r;
  logic              per_write_r;
  logic [1:0]        rsp_valid_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;
`ifndef REG_ARB_FIXED_PRIO_EN
  logic              last_grant_r;
`endif

  // Winner selection; only meaningful while IDLE
  always_comb begin
    accept_s = 1'b0;
    grant_s  = 1'b0;
    if (state_r == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        accept_s = 1'b1;
`ifdef REG_ARB_FIXED_PRIO_EN
        grant_s  = 1'b0;
`else
        grant_s  = ~last_grant_r;
`endif
      end else if (bus.req0_valid) begin
        accept_s = 1'b1;
        grant_s  = 1'b0;
      end else if (bus.req1_valid) begin
        accept_s = 1'b1;
        grant_s  = 1'b1;
      end else begin
        accept_s = 1'b0;
        grant_s  = 1'b0;
      end
    end else begin
      accept_s = 1'b0;
      grant_s  = 1'b0;
    end
  end

  // Request fields of the selected requester
  always_comb begin
    sel_write_s = bus.req0_write;
    sel_addr_s  = bus.req0_addr;
    sel_wdata_s = bus.req0_wdata;
    if (grant_s) begin
      sel_write_s = bus.req1_write;
      sel_addr_s  = bus.req1_addr;
      sel_wdata_s = bus.req1_wdata;
    end else begin
      sel_write_s = bus.req0_write;
      sel_addr_s  = bus.req0_addr;
      sel_wdata_s = bus.req0_wdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE:   state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Transaction latch, peripheral drive and response capture.
  // Read data is captured at the end of ISSUE so it is valid alongside rsp_valid in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r       <= 1'b0;
      write_r       <= 1'b0;
      per_address_r <= {ADDR_W{1'b0}};
      per_data_in_r <= {DATA_W{1'b0}};
      per_write_r   <= 1'b0;
      rsp_valid_r   <= 2'b00;
      rdata0_r      <= {DATA_W{1'b0}};
      rdata1_r      <= {DATA_W{1'b0}};
    end else begin
      per_write_r <= 1'b0;
      rsp_valid_r <= 2'b00;
      if (accept_s) begin
        owner_r       <= grant_s;
        write_r       <= sel_write_s;
        per_address_r <= sel_addr_s;
        per_data_in_r <= sel_wdata_s;
        per_write_r   <= sel_write_s;
      end
      if (state_r == ISSUE) begin
        if (owner_r) begin
          rsp_valid_r <= 2'b10;
          if (!write_r) begin
            rdata1_r <= bus.per_data_out;
          end
        end else begin
          rsp_valid_r <= 2'b01;
          if (!write_r) begin
            rdata0_r <= bus.per_data_out;
          end
        end
      end
    end
  end

`ifndef REG_ARB_FIXED_PRIO_EN
  // Round-robin history; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      last_grant_r <= grant_s;
    end
  end
`endif

  assign bus.req0_ready     = accept_s & ~grant_s;
  assign bus.req1_ready     = accept_s & grant_s;
  assign bus.rsp0_valid     = rsp_valid_r[0];
  assign bus.rsp1_valid     = rsp_valid_r[1];
  assign bus.rsp0_rdata     = rdata0_r;
  assign bus.rsp1_rdata     = rdata1_r;
  assign bus.per_address    = per_address_r;
  assign bus.per_data_in    = per_data_in_r;
  assign bus.per_data_write = per_write_r;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: requests push expected responses,
// a negedge monitor pops and compares them when the DUT responds.
module tb_reg_bus_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit         w;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         due;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] per_mem [16];
  logic [7:0] shadow  [16];
  logic       mem_loaded = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         grant_log[$];
  int         acc_cyc[$];

  // Peripheral model: combinational read, write on strobe
  assign bus.per_data_out = per_mem[bus.per_address];
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) per_mem[i] <= 8'(i);
      per_mem[4]  <= 8'h3C;
      per_mem[15] <= 8'h5A;
      mem_loaded  <= 1'b1;
    end else if (bus.per_data_write) begin
      per_mem[bus.per_address] <= bus.per_data_in;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobe/response checks against the scoreboard queues
  initial begin
    exp_t e;
    logic [7:0] hold0;
    logic [7:0] hold1;
    hold0 = 8'h00;
    hold1 = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold0 = 8'h00;
        hold1 = 8'h00;
      end else begin
        if (bus.req0_ready || bus.req1_ready)
          check("single_grant", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
        if (bus.per_data_write) begin
          if (q0.size() > 0 && q0[0].due == cyc + 1) begin
            e = q0[0];
          end else if (q1.size() > 0 && q1[0].due == cyc + 1) begin
            e = q1[0];
          end else begin
            e.w = 1'b0; e.addr = 4'h0; e.wdata = 8'h00; e.rdata = 8'h00; e.due = -1;
          end
          check("strobe_expected", 32'(e.w), 32'd1);
          if (e.w) begin
            check("strobe_addr", 32'(bus.per_address), 32'(e.addr));
            check("strobe_data", 32'(bus.per_data_in), 32'(e.wdata));
          end
        end
        if (bus.rsp0_valid) begin
          if (q0.size() == 0) begin
            check("unexpected_rsp0", 32'd1, 32'd0);
          end else begin
            e = q0.pop_front();
            check("rsp0_latency", 32'(cyc), 32'(e.due));
            if (!e.w) hold0 = e.rdata;
            check("rsp0_rdata", 32'(bus.rsp0_rdata), 32'(hold0));
            check("rsp1_rdata_held", 32'(bus.rsp1_rdata), 32'(hold1));
          end
        end
        if (bus.rsp1_valid) begin
          if (q1.size() == 0) begin
            check("unexpected_rsp1", 32'd1, 32'd0);
          end else begin
            e = q1.pop_front();
            check("rsp1_latency", 32'(cyc), 32'(e.due));
            if (!e.w) hold1 = e.rdata;
            check("rsp1_rdata", 32'(bus.rsp1_rdata), 32'(hold1));
            check("rsp0_rdata_held", 32'(bus.rsp0_rdata), 32'(hold0));
          end
        end
      end
    end
  end

  task automatic drive(input bit r, input bit v, input bit w, input logic [3:0] a, input logic [7:0] d);
    if (r == 1'b0) begin
      bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  // Issue one request and hold it until accepted (bounded)
  task automatic do_req(input bit r, input bit w, input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    bit   got;
    logic rdy;
    got = 1'b0;
    @(negedge clk);
    drive(r, 1'b1, w, a, d);
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      rdy = (r == 1'b0) ? bus.req0_ready : bus.req1_ready;
      if (rdy) begin
        got     = 1'b1;
        e.w     = w;
        e.addr  = a;
        e.wdata = d;
        e.rdata = w ? 8'h00 : shadow[a];
        e.due   = cyc + 2;
        if (w) shadow[a] = d;
        if (r == 1'b0) q0.push_back(e); else q1.push_back(e);
        grant_log.push_back(int'(r));
        acc_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        drive(r, 1'b0, w, a, d);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      check(r ? "ready_timeout_req1" : "ready_timeout_req0", 32'd0, 32'd1);
      drive(r, 1'b0, w, a, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = 8'(i);
    shadow[4]  = 8'h3C;
    shadow[15] = 8'h5A;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);

    // Reset values
    #12;
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    check("rst_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    check("rst_per_address", 32'(bus.per_address), 32'd0);
    check("rst_per_data_in", 32'(bus.per_data_in), 32'd0);
    check("rst_per_write", 32'(bus.per_data_write), 32'd0);
    check("rst_rdata", 32'({bus.rsp1_rdata, bus.rsp0_rdata}), 32'd0);
    @(posedge clk); #2; rst_n = 1'b1;

    // Single accesses
    do_req(1'b1, 1'b0, 4'h4, 8'h00);
    do_req(1'b0, 1'b1, 4'h4, 8'hA5);
    do_req(1'b0, 1'b0, 4'h4, 8'h00);
    do_req(1'b1, 1'b1, 4'h6, 8'hC3);

    // Back-to-back read 0xF then write 0x0 from requester 0
    do_req(1'b0, 1'b0, 4'hF, 8'h00);
    do_req(1'b0, 1'b1, 4'h0, 8'h77);
    repeat (4) @(negedge clk);
    check("per_address_wrap", 32'(bus.per_address), 32'd0);

    // Reset while a write is in ISSUE
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 4'h9, 8'hEE);
    #1 check("midrst_ready", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 4'h9, 8'hEE);
    check("midrst_strobe_before", 32'(bus.per_data_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_strobe_after", 32'(bus.per_data_write), 32'd0);
    check("midrst_per_address", 32'(bus.per_address), 32'd0);
    check("midrst_per_data_in", 32'(bus.per_data_in), 32'd0);
    check("midrst_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    check("midrst_rdata", 32'({bus.rsp1_rdata, bus.rsp0_rdata}), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Both requesters busy from reset
    grant_log.delete();
    acc_cyc.delete();
    fork
      begin
        do_req(1'b0, 1'b1, 4'h2, 8'h11);
        do_req(1'b0, 1'b0, 4'h2, 8'h00);
      end
      begin
        do_req(1'b1, 1'b1, 4'h3, 8'h22);
        do_req(1'b1, 1'b0, 4'h3, 8'h00);
      end
    join
    if (grant_log.size() == 4 && acc_cyc.size() == 4) begin
`ifdef REG_ARB_FIXED_PRIO_EN
      check("tie_order", 32'({grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0], grant_log[3][3:0]}), 32'h0011);
`else
      check("tie_order", 32'({grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0], grant_log[3][3:0]}), 32'h0101);
`endif
      for (int i = 1; i < 4; i++) check("accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    end else begin
      check("grant_count", 32'(grant_log.size()), 32'd4);
    end

    // Dropped write must not have reached the peripheral
    do_req(1'b1, 1'b0, 4'h9, 8'h00);

    repeat (5) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
